// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads three bytes {opcode, operand1, operand2}
// from an 8-bit RAM and holds them for decode. Optional HALT state: FETCH_HALT_EN.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        pc_load,
  input  logic [7:0]  pc_load_addr,
  input  logic        ir_ready,
  output logic        ir_valid,
  output logic [23:0] command_word,
  output logic [7:0]  opcode,
  output logic [7:0]  operand1,
  output logic [7:0]  operand2,
  output logic [7:0]  instr_pc,
  output logic        halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [2:0] {IDLE, B0, B1, B2, HOLD, HALT} state_t;
`else
  typedef enum logic [2:0] {IDLE, B0, B1, B2, HOLD} state_t;
`endif

  localparam logic [7:0] HALT_OPCODE = 8'hFF;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [23:0] cmd_q, cmd_d;
  logic [7:0]  ipc_q, ipc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cmd_q   <= 24'h000000;
      ipc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cmd_q   <= cmd_d;
      ipc_q   <= ipc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cmd_d    = cmd_q;
    ipc_d    = ipc_q;
    mem_rd   = 1'b0;
    mem_addr = pc_q;

    case (state_q)
      IDLE: state_d = B0;
      B0: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          cmd_d[23:16] = mem_rdata;
          ipc_d        = pc_q;
          pc_d         = pc_q + 8'd1;
          state_d      = B1;
        end
      end
      B1: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          cmd_d[15:8] = mem_rdata;
          pc_d        = pc_q + 8'd1;
          state_d     = B2;
        end
      end
      B2: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          cmd_d[7:0] = mem_rdata;
          pc_d       = pc_q + 8'd1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (ir_ready) begin
`ifdef FETCH_HALT_EN
          state_d = (cmd_q[23:16] == HALT_OPCODE) ? HALT : B0;
`else
          state_d = B0;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IDLE;
    endcase

    // A redirect wins over everything except reset; any bytes gathered so far are dropped.
    if (pc_load) begin
      pc_d    = pc_load_addr;
      cmd_d   = cmd_q;
      ipc_d   = ipc_q;
      state_d = B0;
    end
  end

  assign ir_valid     = (state_q == HOLD);
  assign command_word = cmd_q;
  assign opcode       = cmd_q[23:16];
  assign operand1     = cmd_q[15:8];
  assign operand2     = cmd_q[7:0];
  assign instr_pc     = ipc_q;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        pc_load;
  logic [7:0]  pc_load_addr;
  logic        ir_ready;
  logic        ir_valid;
  logic [23:0] command_word;
  logic [7:0]  opcode, operand1, operand2, instr_pc;
  logic        halted;

  logic [7:0]  ram [256];

  always #5 clk = ~clk;

  assign mem_rdata = mem_ready ? ram[mem_addr] : 8'hEE;

  instr_fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .ir_ready     (ir_ready),
    .ir_valid     (ir_valid),
    .command_word (command_word),
    .opcode       (opcode),
    .operand1     (operand1),
    .operand2     (operand2),
    .instr_pc     (instr_pc),
    .halted       (halted)
  );

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else
      passed++;
  endtask

  // Model: phase -1 = start-up cycle, 0..2 = waiting for byte k,
  // 3 = instruction on offer, 4 = stopped on HALT.
  int          m_phase;
  logic [7:0]  m_pc, m_ipc;
  logic [23:0] m_cmd;
  bit          m_known = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("mem_rd", 32'(mem_rd), 32'(m_phase >= 0 && m_phase <= 2));
        if (m_phase >= 0 && m_phase <= 2)
          chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        chk("ir_valid", 32'(ir_valid), 32'(m_phase == 3));
        chk("halted", 32'(halted), 32'(m_phase == 4));
        if (m_phase == 3) begin
          chk("command_word", 32'(command_word), 32'(m_cmd));
          chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
          chk("opcode", 32'(opcode), 32'(m_cmd[23:16]));
          chk("operand1", 32'(operand1), 32'(m_cmd[15:8]));
          chk("operand2", 32'(operand2), 32'(m_cmd[7:0]));
        end
      end
      if (rst) begin
        m_known = 1'b1;
        m_phase = -1;
        m_pc    = 8'h00;
        m_cmd   = 24'h0;
        m_ipc   = 8'h00;
      end else if (m_known) begin
        if (pc_load) begin
          m_pc    = pc_load_addr;
          m_phase = 0;
        end else if (m_phase == -1) begin
          m_phase = 0;
        end else if (m_phase <= 2) begin
          if (mem_ready) begin
            if (m_phase == 0) m_ipc = m_pc;
            m_cmd   = {m_cmd[15:0], ram[m_pc]};
            m_pc    = m_pc + 8'd1;
            m_phase = m_phase + 1;
          end
        end else if (m_phase == 3) begin
          if (ir_ready) m_phase = (HALT_EN && m_cmd[23:16] == 8'hFF) ? 4 : 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pc_load = 1'b0;
    step();
    step();
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_command_word", 32'(command_word), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_load = 1'b0; pc_load_addr = 8'h00;
    ir_ready = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);

    // Back-to-back instructions, everything ready
    ram[0] = 8'h01; ram[1] = 8'h00; ram[2] = 8'h02;
    ram[3] = 8'h03; ram[4] = 8'h00; ram[5] = 8'h01;
    do_reset();
    chk("first_cycle_no_rd", 32'(mem_rd), 32'd0);
    step();
    chk("first_rd", 32'(mem_rd), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'h00);
    repeat (3) step();
    chk("i0_valid", 32'(ir_valid), 32'd1);
    chk("i0_cmd", 32'(command_word), 32'h010002);
    chk("i0_pc", 32'(instr_pc), 32'h00);
    step();
    chk("i0_pulse", 32'(ir_valid), 32'd0);
    chk("i1_addr", 32'(mem_addr), 32'h03);
    repeat (3) step();
    chk("i1_valid", 32'(ir_valid), 32'd1);
    chk("i1_cmd", 32'(command_word), 32'h030001);
    chk("i1_pc", 32'(instr_pc), 32'h03);
    step();
    chk("i1_pulse", 32'(ir_valid), 32'd0);

    // Memory stall during the second byte
    do_reset();
    step(); step();
    mem_ready = 1'b0;
    step();
    chk("stall_addr_a", 32'(mem_addr), 32'h01);
    chk("stall_rd", 32'(mem_rd), 32'd1);
    step();
    chk("stall_addr_b", 32'(mem_addr), 32'h01);
    mem_ready = 1'b1;
    step();
    chk("stall_not_yet", 32'(ir_valid), 32'd0);
    step();
    chk("stall_valid", 32'(ir_valid), 32'd1);
    chk("stall_cmd", 32'(command_word), 32'h010002);

    // Decode back-pressure
    do_reset();
    ir_ready = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(ir_valid), 32'd1);
      chk("bp_cmd", 32'(command_word), 32'h010002);
      chk("bp_no_rd", 32'(mem_rd), 32'd0);
      step();
    end
    ir_ready = 1'b1;
    step();
    chk("bp_release_addr", 32'(mem_addr), 32'h03);
    chk("bp_release_valid", 32'(ir_valid), 32'd0);

    // Redirect in the middle of an instruction
    ram[8'h40] = 8'h11; ram[8'h41] = 8'h22; ram[8'h42] = 8'h33;
    do_reset();
    step(); step();
    pc_load = 1'b1; pc_load_addr = 8'h40;
    step();
    pc_load = 1'b0;
    chk("jmp_addr", 32'(mem_addr), 32'h40);
    chk("jmp_rd", 32'(mem_rd), 32'd1);
    chk("jmp_valid", 32'(ir_valid), 32'd0);
    repeat (3) step();
    chk("jmp_cmd", 32'(command_word), 32'h112233);
    chk("jmp_pc", 32'(instr_pc), 32'h40);

    // Instruction straddling the top of memory
    ram[8'hFE] = 8'hA1; ram[8'hFF] = 8'hB2; ram[8'h00] = 8'hC3;
    do_reset();
    pc_load = 1'b1; pc_load_addr = 8'hFE;
    step();
    pc_load = 1'b0;
    chk("wrap_start", 32'(mem_addr), 32'hFE);
    repeat (3) step();
    chk("wrap_cmd", 32'(command_word), 32'hA1B2C3);
    chk("wrap_pc", 32'(instr_pc), 32'hFE);
    step();
    chk("wrap_next", 32'(mem_addr), 32'h01);

    // HALT opcode
    ram[0] = 8'hFF; ram[1] = 8'h00; ram[2] = 8'h00;
    do_reset();
    repeat (4) step();
    chk("halt_cmd", 32'(command_word), 32'hFF0000);
    step();
`ifdef FETCH_HALT_EN
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_no_rd", 32'(mem_rd), 32'd0);
    repeat (3) step();
    chk("halt_stays", 32'(halted), 32'd1);
    pc_load = 1'b1; pc_load_addr = 8'h00;
    step();
    pc_load = 1'b0;
    chk("halt_clear", 32'(halted), 32'd0);
    chk("halt_resume_addr", 32'(mem_addr), 32'h00);
`else
    chk("nohalt_flag", 32'(halted), 32'd0);
    chk("nohalt_addr", 32'(mem_addr), 32'h03);
    chk("nohalt_rd", 32'(mem_rd), 32'd1);
`endif

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      pc_load      = ($urandom_range(0, 24) == 0);
      pc_load_addr = 8'($urandom);
      mem_ready    = ($urandom_range(0, 9) < 7);
      ir_ready     = ($urandom_range(0, 9) < 6);
      step();
    end

    rst = 1'b1; pc_load = 1'b0;
    step(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port mem_addr  output  8  byte address presented to instruction RAM.
REQ-005 SHALL have port mem_rd  output  1  read request, valid with mem_addr.
REQ-006 SHALL have port mem_rdata  input  8  RAM read data, valid when mem_ready=1.
REQ-007 SHALL have port mem_ready  input  1  RAM completes the current read this cycle.
REQ-008 SHALL have port pc_load  input  1  redirect fetch (jump/branch taken).
REQ-009 SHALL have port pc_load_addr  input  8  redirect target address.
REQ-010 SHALL have port ir_ready  input  1  decode/execute stage accepts the held instruction.
REQ-011 SHALL have port ir_valid  output  1  command_word holds a complete instruction.
REQ-012 SHALL have port command_word  output  24  {opcode, operand1, operand2}.
REQ-013 SHALL have port opcode, operand1, operand2  output  8 each  slices [23:16], [15:8], [7:0] of command_word.
REQ-014 SHALL have port instr_pc  output  8  address of the opcode byte of the held instruction.
REQ-015 SHALL have port halted  output  1  fetch stopped on HALT opcode.

Function
REQ-016 SHALL implement FSM states IDLE, B0, B1, B2, HOLD, and HALT (HALT only when FETCH_HALT_EN is defined).
REQ-017 SHALL, in state Bn, drive mem_rd=1 and mem_addr=pc (combinational from state and pc); mem_rd=0 in every other state.
REQ-018 SHALL transition IDLE->B0 unconditionally.
REQ-019 SHALL, in Bn with mem_ready=1, capture mem_rdata into byte n, increment pc by 1, and advance B0->B1->B2->HOLD.
REQ-020 SHALL, in Bn with mem_ready=0, hold state, pc, and captured bytes.
REQ-021 SHALL wrap pc modulo 256 (8'hFF+1 = 8'h00), including within an instruction.
REQ-022 SHALL latch instr_pc = pc on B0 capture.
REQ-023 SHALL assert ir_valid=1 only in HOLD, keeping command_word and instr_pc stable while there.
REQ-024 SHALL, in HOLD with ir_ready=1, move to B0 next cycle, so ir_valid drops the following cycle.
REQ-025 SHALL need 4 cycles per instruction (3 fetch + 1 handshake) with mem_ready and ir_ready tied high.
REQ-026 SHALL make pc_load highest priority after rst: in any state, pc <= pc_load_addr, discard partial bytes, force ir_valid=0 next cycle, and go to B0.
REQ-027 SHALL, on pc_load and ir_ready in the same HOLD cycle, treat the held instruction as consumed and apply the load.
REQ-028 SHALL ignore ir_ready outside HOLD.
REQ-029 SHALL ignore mem_rdata and mem_ready outside Bn.

Reset
REQ-030 SHALL, when rst is sampled high, set state=IDLE, pc=RESET_PC, command_word=0, instr_pc=0, ir_valid=0, halted=0, with mem_rd=0.
REQ-031 SHALL let rst override pc_load and any in-progress fetch; partial bytes are lost.
REQ-032 SHALL issue the first mem_rd in the second cycle after rst is deasserted (IDLE then B0).

Configuration
REQ-033 SHALL, with FETCH_HALT_EN defined, go HOLD->HALT instead of B0 on ir_ready when opcode==8'hFF.
REQ-034 SHALL, with FETCH_HALT_EN defined, hold halted=1 and mem_rd=0 in HALT, and leave HALT only via rst (to IDLE) or pc_load (to B0, halted=0).
REQ-035 SHALL, without FETCH_HALT_EN, treat opcode 8'hFF as ordinary, omit the HALT state, and tie halted to 0 with the port retained.

Verification
REQ-036 SHALL cover: RAM[0..2]=01,00,02; RAM[3..5]=03,00,01; mem_ready=1, ir_ready=1 -> command_word 24'h010002 with instr_pc=00, then 24'h030001 with instr_pc=03, each ir_valid pulse 1 cycle and 4 cycles apart.
REQ-037 SHALL cover: mem_ready low 2 cycles during B1 -> command_word still 24'h010002; ir_valid 2 cycles later than REQ-036; mem_addr held at 01 while stalled.
REQ-038 SHALL cover: ir_ready=0 for 5 cycles in HOLD -> ir_valid and command_word stable, mem_rd=0, pc=03.
REQ-039 SHALL cover: pc_load=1, pc_load_addr=8'h40 during B1 -> next cycle B0, mem_addr=40, ir_valid=0, next instruction instr_pc=40.
REQ-040 SHALL cover: instruction at 8'hFE (bytes at FE, FF, 00) -> correct command_word, instr_pc=FE, next fetch at 01.
REQ-041 SHALL cover: with FETCH_HALT_EN, RAM[0..2]=FF,00,00 -> halted=1 and mem_rd=0 after ir_ready; pc_load to 8'h00 clears halted; without the macro, fetch continues at 03.
